// File: rtl/aes192_key_expand_seq.sv
// aes192_key_expand_seq: iterative AES-192 key schedule (one word per clock) with a registered round-key read port
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, b;
    p = '0;
    b = x;
    for (int k = 0; k < 8; k++) begin
      p = y[k] ? p ^ b : p;
      b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  logic [7:0] inv;
  always_comb begin
    inv = 8'h01;
    for (int k = 0; k < 7; k++) inv = gmul(gmul(inv, inv), a);
    inv = gmul(inv, inv);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end
endmodule

module aes192_key_expand_seq #(
  parameter int NK = 6,
  parameter int NR = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [191:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         keys_valid,
  input  logic [3:0]   rk_sel,
  output logic [127:0] rk_out
);
  localparam int NW = 4 * (NR + 1);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state_q, state_d;
  logic [5:0] i_q, i_d;
  logic done_q, done_d;
  logic [127:0] rk_q, rk_d;
  logic [31:0] w_q [NW];
  logic [31:0] w_d [NW];
  logic [31:0] prev, rot, sub, temp;
  logic [7:0] rcon;
  logic [5:0] rk_base;
  logic last;
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*b +: 8]), .s(sub[8*b +: 8]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      done_q  <= 1'b0;
      rk_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      done_q  <= done_d;
      rk_q    <= rk_d;
    end
  end
  always_ff @(posedge clk) w_q <= w_d;
  always_comb begin
    state_d = (state_q == EXPAND) ? (last ? DONE : EXPAND) : (start ? EXPAND : state_q);
  end
  always_comb begin
    prev    = w_q[i_q - 6'd1];
    rot     = {prev[23:0], prev[31:24]};
    rcon    = 8'h01 << (i_q / 6'(NK) - 6'd1);
    temp    = (i_q % 6'(NK) == 6'd0) ? sub ^ {rcon, 24'h0} : prev;
    last    = i_q == 6'(NW - 1);
    i_d     = (state_q != EXPAND) ? (start ? 6'(NK) : i_q) : (last ? i_q : i_q + 6'd1);
    done_d  = state_q == EXPAND && last;
    w_d     = w_q;
    if (state_q != EXPAND && start)
      for (int k = 0; k < NK; k++) w_d[k] = key_in[32*(NK-1-k) +: 32];
    if (state_q == EXPAND) w_d[i_q] = w_q[i_q - 6'(NK)] ^ temp;
    rk_base = {rk_sel, 2'b00};
    rk_d    = (keys_valid && rk_sel <= 4'(NR)) ?
              {w_q[rk_base], w_q[rk_base + 6'd1], w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]} : '0;
  end
  always_comb begin
    busy       = state_q == EXPAND;
    keys_valid = state_q == DONE;
    done       = done_q;
    rk_out     = rk_q;
  end
endmodule

// File: tb/tb_aes192_key_expand_seq.sv
// tb_aes192_key_expand_seq: randomized scoreboard bench against a FIPS-197 key-schedule model
module tb_aes192_key_expand_seq;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [191:0] key_in = '0;
  logic busy, done, keys_valid;
  logic [3:0] rk_sel = '0;
  logic [127:0] rk_out;
  aes192_key_expand_seq dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in), .busy(busy), .done(done),
    .keys_valid(keys_valid), .rk_sel(rk_sel), .rk_out(rk_out)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, cyc = 0;
  logic rd_req = 1'b0, rd_pend = 1'b0;
  logic [127:0] exp_q[$];
  int done_q[$];
  logic [7:0] sbox [256];
  logic [31:0] mw [52];
  logic [127:0] model_rk [13];
  logic model_valid = 1'b0;
  localparam logic [191:0] KEY1 = 192'h8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b;
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rd_underflow: read with no expected value at cycle %0d", cyc);
      end else chk("rk_out", rk_out, exp_q.pop_front());
    end
    if (done === 1'b1) begin
      if (done_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: pulse at cycle %0d, none expected", cyc);
      end else chk("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
    end
  end
  task automatic gen_sbox();
    logic [7:0] p, q, x;
    p = 8'h01; q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      q = q[7] ? q ^ 8'h09 : q;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sbox[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox[0] = 8'h63;
  endtask
  task automatic model_expand(input logic [191:0] k);
    logic [31:0] t;
    int rc;
    for (int i = 0; i < 6; i++) mw[i] = k[191-32*i -: 32];
    for (int i = 6; i < 52; i++) begin
      t = mw[i-1];
      if (i % 6 == 0) begin
        rc = 1 << (i / 6 - 1);
        t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc[7:0], 24'h0};
      end
      mw[i] = mw[i-6] ^ t;
    end
    for (int r = 0; r < 13; r++) model_rk[r] = {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endtask
  function automatic logic [127:0] mexp(input logic [3:0] s);
    return (model_valid && s <= 4'd12) ? model_rk[s] : '0;
  endfunction
  function automatic logic [191:0] rkey();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic neg();
    @(negedge clk);
    rd_req = 1'b0;
    if (done === 1'b1) model_valid = 1'b1;
  endtask
  task automatic rd(input logic [3:0] s, input bit known, input logic [127:0] e);
    @(negedge clk);
    if (done === 1'b1) model_valid = 1'b1;
    rk_sel = s;
    rd_req = 1'b1;
    exp_q.push_back(known ? e : mexp(s));
  endtask
  task automatic rd_rand(input int n);
    for (int j = 0; j < n; j++) rd(4'($urandom_range(0, 15)), 1'b0, '0);
  endtask
  task automatic do_start(input logic [191:0] k);
    neg();
    key_in = k;
    start = 1'b1;
    model_valid = 1'b0;
    model_expand(k);
    done_q.push_back(cyc + 47);
    neg();
    start = 1'b0;
    key_in = rkey();
    chk("busy_after_start", 128'(busy), 128'(1'b1));
    chk("kv_after_start", 128'(keys_valid), 128'(1'b0));
  endtask
  task automatic wait_done();
    int n = 0;
    do begin
      rd(4'($urandom_range(0, 15)), 1'b0, '0);
      n++;
    end while (done !== 1'b1 && n < 60);
    chk("done_seen", 128'(done === 1'b1), 128'(1'b1));
    chk("kv_after_done", 128'(keys_valid), 128'(1'b1));
    chk("busy_after_done", 128'(busy), 128'(1'b0));
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog timeout");
  end
  initial begin
    logic [191:0] ka, kb;
    gen_sbox();
    repeat (3) neg();
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_done", 128'(done), 128'(1'b0));
    chk("rst_kv", 128'(keys_valid), 128'(1'b0));
    chk("rst_rk_out", rk_out, '0);
    neg();
    reset = 1'b0;
    rd_rand(6);
    do_start(KEY1);
    wait_done();
    rd(4'd0, 1'b1, 128'h8e73b0f7da0e6452c810f32b809079e5);
    rd(4'd1, 1'b1, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    rd(4'd12, 1'b1, 128'he98ba06f448c773c8ecc720401002202);
    rd(4'd13, 1'b1, '0);
    rd(4'd15, 1'b1, '0);
    for (int s = 0; s < 13; s++) rd(4'(s), 1'b0, '0);
    ka = rkey();
    kb = rkey();
    do_start(ka);
    rd_rand(18);
    neg();
    start = 1'b1;
    key_in = kb;
    neg();
    start = 1'b0;
    wait_done();
    rd(4'd0, 1'b1, ka[191:64]);
    rd_rand(16);
    do_start(rkey());
    rd_rand(28);
    neg();
    reset = 1'b1;
    void'(done_q.pop_back());
    neg();
    reset = 1'b0;
    chk("abort_busy", 128'(busy), 128'(1'b0));
    chk("abort_kv", 128'(keys_valid), 128'(1'b0));
    rd_rand(50);
    neg();
    reset = 1'b1;
    start = 1'b1;
    key_in = rkey();
    neg();
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", 128'(busy), 128'(1'b0));
    chk("rst_start_kv", 128'(keys_valid), 128'(1'b0));
    do_start(rkey());
    wait_done();
    for (int s = 0; s < 16; s++) rd(4'(s), 1'b0, '0);
    do_start('0);
    wait_done();
    rd(4'd1, 1'b1, 128'h0000000000000000_62636363_62636363);
    rd(4'd12, 1'b0, '0);
    rd_rand(20);
    neg();
    neg();
    neg();
    chk("exp_q_empty", 128'(exp_q.size()), '0);
    chk("done_q_empty", 128'(done_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes192_key_expand_seq.md
Name: aes192_key_expand_seq

Overview:
Iterative AES-192 key-schedule engine that sits directly upstream of the AES-192 encrypt/decrypt datapath. It feeds that datapath its round keys.
- Captures a 192-bit cipher key and generates all 52 expanded words (FIPS-197), one word per clock, using a single SubWord unit built from 4 instances of the team's existing byte S-box.
- Stores the 13 round keys and serves any one of them through an indexed, registered read port.
- Both the encrypt path (forward index order) and the decrypt path (reverse index order) read from that port.

Parameters:
NK, 6, key length in 32-bit words; only the default is supported.
NR, 12, number of rounds; round keys stored = NR+1 = 13; only the default is supported.

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin expansion of key_in
key_in  input  192  cipher key; key_in[191:160] = w0 ... key_in[31:0] = w5
busy  output  1  high while expansion is in progress
done  output  1  one-cycle pulse when the last word w51 has been written
keys_valid  output  1  high while the stored schedule is complete and current
rk_sel  input  4  round-key index 0..12
rk_out  output  128  round key {w[4*rk_sel], w[4*rk_sel+1], w[4*rk_sel+2], w[4*rk_sel+3]}, registered

Behaviour:
- States: IDLE, EXPAND, DONE. Reset moves to IDLE.
- Reset values: busy=0, done=0, keys_valid=0, rk_out=0, word index=0. Word storage is not reset.
- In IDLE or DONE, start=1 at edge E0:
  - latch w0..w5 from key_in;
  - set word index i=6;
  - go to EXPAND: busy=1, keys_valid=0.
- start while in EXPAND is ignored; no restart and no key re-capture.
- EXPAND, each edge:
  - temp = w[i-1];
  - if i mod 6 == 0: temp = SubWord(RotWord(temp)) XOR {Rcon[i/6], 24'h0}, with Rcon[1..8] = 01,02,04,08,10,20,40,80;
  - w[i] = w[i-6] XOR temp; then i++.
  - RotWord is a left byte rotate.
- Edge E46 writes w51. After E46: state=DONE, busy=0, keys_valid=1, done=1 for exactly one cycle.
- Total latency: done visible 46 cycles after the start edge.
- i is 6 bits. It never exceeds 51 and never wraps.
- Read port: rk_out is updated every edge.
  - rk_out = stored round key[rk_sel] if keys_valid=1 and rk_sel<=12;
  - otherwise rk_out = 128'h0.
  - Latency 1 cycle from rk_sel.
  - rk_sel 13..15 always returns zero.
- Restart from DONE:
  - keys_valid falls and busy rises on the start edge;
  - rk_out reads zero from the following edge until the new done.
- Reset mid-expansion: next state IDLE; busy=0, keys_valid=0, no done pulse; partial words are discarded.
- reset and start in the same cycle: reset wins, state IDLE.
- Exactly one w[i] write per EXPAND cycle. No stall input; the consumer waits for keys_valid.

Test Plan:
1. Reset, then start with key_in=8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b -> busy=1 next cycle; done pulses exactly 46 cycles after the start edge; keys_valid=1 after that.
2. After scenario 1, rk_sel=0 -> rk_out=8e73b0f7da0e6452c810f32b809079e5 one cycle later. rk_sel=1 -> 62f8ead2522c6b7bfe0c91f72402f5a5. rk_sel=12 -> e98ba06f448c773c8ecc720401002202.
3. rk_sel=13 and rk_sel=15 with keys_valid=1 -> rk_out=0. Any rk_sel before the first done -> rk_out=0.
4. Pulse start again at cycle 20 of an expansion, with a different key_in -> ignored; done still at cycle 46; rk 0 still equals the first key.
5. Assert reset at cycle 30 of an expansion -> busy=0, keys_valid=0, done never pulses. A new start then completes normally in 46 cycles with correct keys.
6. From DONE, start with key_in all zero -> keys_valid drops on that edge; after the new done, rk_sel=1 -> rk_out=0000000000000000_62636363_62636363 and rk_sel=12 -> the FIPS-197 zero-key AES-192 round 12 value (cross-checked against the reference model).
